dot_overlay_engine: RTL and testbench

DOT_OVERLAY_ENGINE -- requirements
Module: dot_overlay_engine

---
 rtl/dot_overlay_engine.sv | 213 +++++++++++++++++++++
 tb/tb_dot_overlay_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_overlay_engine.sv
// -----------------------------------------------------------------------------
// dot_overlay_engine
//
// Draws NUM_DOTS square dots and one goal square over a background colour on a
// VGA-style pixel stream. Each dot position has two copies:
//   - a shadow copy, written by the processor at any time;
//   - a displayed copy, used for drawing.
// All shadow positions are copied to the displayed positions in one clk on the
// rising edge of screen_end, so a frame never shows a half-updated position.
//
// Optional feature macro: DOT_OVERLAY_CHAMPION_EN
//   defined   -> a pixel whose lowest-index hitting dot is dot 0 is drawn
//                12'hF00 (champion colour); all other dots stay 12'h000.
//   undefined -> every dot is drawn 12'h000; no champion logic is built.
//
// Ports
//   clk        in   1   100 MHz system clock
//   reset      in   1   asynchronous, active-low reset
//   pix_en     in   1   one-clk strobe per 25 MHz pixel
//   x          in  10   current pixel column
//   y          in   9   current pixel row
//   active     in   1   visible region
//   screen_end in   1   high between frames
//   wr_en      in   1   position write request
//   wr_is_y    in   1   1 writes y, 0 writes x
//   wr_id      in  32   dot index
//   wr_data    in  32   new coordinate (x uses [9:0], y uses [8:0])
//   wr_ack     out  1   write accepted pulse
//   bg_color   in  12   background palette colour
//   rgb_out    out 12   {R,G,B} to the pins
//   hit_any    out  1   pixel covered by any dot
//   hit_id     out  5   lowest-index dot covering the pixel
//
// Write handshake: wr_en is a valid-only strobe. There is no ready; every
// cycle with wr_en=1 is taken (or discarded when wr_id>=NUM_DOTS) and is
// answered by a one-clk wr_ack on the following cycle, one write per clk.
// -----------------------------------------------------------------------------
module dot_overlay_engine #(
  parameter int          NUM_DOTS   = 8,
  parameter int          DOT_SIZE   = 1,
  parameter int          HOME_X     = 320,
  parameter int          HOME_Y     = 240,
  parameter int          GOAL_X     = 310,
  parameter int          GOAL_Y     = 50,
  parameter int          GOAL_SIZE  = 20,
  parameter logic [11:0] GOAL_COLOR = 12'h0D0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        active,
  input  logic        screen_end,
  input  logic        wr_en,
  input  logic        wr_is_y,
  input  logic [31:0] wr_id,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  input  logic [11:0] bg_color,
  output logic [11:0] rgb_out,
  output logic        hit_any,
  output logic [4:0]  hit_id
);

  localparam logic [9:0]  HOME_X_V  = 10'(HOME_X);
  localparam logic [8:0]  HOME_Y_V  = 9'(HOME_Y);
  localparam logic [31:0] NUM_DOTS_V = 32'(NUM_DOTS);

  // Range compares are done one bit wider than the coordinate so that
  // position + size can never wrap back to a small value at the screen edge.
  localparam logic [10:0] DOT_SIZE_X = 11'(DOT_SIZE);
  localparam logic [9:0]  DOT_SIZE_Y = 10'(DOT_SIZE);
  localparam logic [10:0] GOAL_X_LO  = 11'(GOAL_X);
  localparam logic [10:0] GOAL_X_HI  = 11'(GOAL_X + GOAL_SIZE);
  localparam logic [9:0]  GOAL_Y_LO  = 10'(GOAL_Y);
  localparam logic [9:0]  GOAL_Y_HI  = 10'(GOAL_Y + GOAL_SIZE);

  localparam logic [11:0] DOT_COLOR = 12'h000;
`ifdef DOT_OVERLAY_CHAMPION_EN
  localparam logic [11:0] CHAMPION_COLOR = 12'hF00;
`endif

  // ---------------------------------------------------------------------------
  // Position storage
  // ---------------------------------------------------------------------------
  logic [9:0] shadow_x [NUM_DOTS];
  logic [8:0] shadow_y [NUM_DOTS];
  logic [9:0] disp_x   [NUM_DOTS];
  logic [8:0] disp_y   [NUM_DOTS];

  logic       wr_take;      // write targets an existing dot
  logic       screen_end_q; // previous screen_end, for edge detection
  logic       commit;       // rising edge of screen_end

  assign wr_take = wr_en && (wr_id < NUM_DOTS_V);
  assign commit  = screen_end && !screen_end_q;

  // Only the low coordinate bits of wr_data are meaningful.
  logic unused_wr_data;
  assign unused_wr_data = &{1'b0, wr_data[31:10]};

  // Shadow copy: processor side, written on any clk regardless of pix_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DOTS; i++) begin
        shadow_x[i] <= HOME_X_V;
        shadow_y[i] <= HOME_Y_V;
      end
    end else begin
      for (int i = 0; i < NUM_DOTS; i++) begin
        if (wr_take && (wr_id[4:0] == 5'(i))) begin
          if (wr_is_y) shadow_y[i] <= wr_data[8:0];
          else         shadow_x[i] <= wr_data[9:0];
        end
      end
    end
  end

  // Displayed copy: loaded from the shadow copy on the commit edge. Because
  // both registers update on the same edge, a write landing on the commit clk
  // is not seen here until the next commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DOTS; i++) begin
        disp_x[i] <= HOME_X_V;
        disp_y[i] <= HOME_Y_V;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_DOTS; i++) begin
        disp_x[i] <= shadow_x[i];
        disp_y[i] <= shadow_y[i];
      end
    end
  end

  // Edge register and write acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      screen_end_q <= 1'b0;
      wr_ack       <= 1'b0;
    end else begin
      screen_end_q <= screen_end;
      wr_ack       <= wr_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel hit logic
  // ---------------------------------------------------------------------------
  logic [10:0]         x_w;
  logic [9:0]          y_w;
  logic [NUM_DOTS-1:0] dot_hit;
  logic                any_hit;
  logic [4:0]          first_id;
  logic                goal_hit;
  logic [11:0]         pix_rgb;

  assign x_w = {1'b0, x};
  assign y_w = {1'b0, y};

  always_comb begin
    dot_hit = '0;
    for (int i = 0; i < NUM_DOTS; i++) begin
      dot_hit[i] = (x_w >= {1'b0, disp_x[i]}) &&
                   (x_w <  ({1'b0, disp_x[i]} + DOT_SIZE_X)) &&
                   (y_w >= {1'b0, disp_y[i]}) &&
                   (y_w <  ({1'b0, disp_y[i]} + DOT_SIZE_Y));
    end
  end

  // Lowest hitting index: scan downward so the smallest index wins.
  always_comb begin
    first_id = 5'd0;
    for (int i = NUM_DOTS - 1; i >= 0; i--) begin
      if (dot_hit[i]) first_id = 5'(i);
    end
  end

  assign any_hit  = |dot_hit;
  assign goal_hit = (x_w >= GOAL_X_LO) && (x_w < GOAL_X_HI) &&
                    (y_w >= GOAL_Y_LO) && (y_w < GOAL_Y_HI);

  // Colour priority: blanking, dot, goal, background.
  always_comb begin
    pix_rgb = bg_color;
    if (!active) begin
      pix_rgb = 12'h000;
    end else if (any_hit) begin
`ifdef DOT_OVERLAY_CHAMPION_EN
      pix_rgb = (first_id == 5'd0) ? CHAMPION_COLOR : DOT_COLOR;
`else
      pix_rgb = DOT_COLOR;
`endif
    end else if (goal_hit) begin
      pix_rgb = GOAL_COLOR;
    end
  end

  // One pix_en of latency from x/y/active to the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_out <= 12'h000;
      hit_any <= 1'b0;
      hit_id  <= 5'd0;
    end else if (pix_en) begin
      rgb_out <= pix_rgb;
      hit_any <= any_hit;
      hit_id  <= any_hit ? first_id : 5'd0;
    end
  end

endmodule

// File: tb/tb_dot_overlay_engine.sv
module tb_dot_overlay_engine;

`ifdef DOT_OVERLAY_CHAMPION_EN
  localparam logic [11:0] CHAMP = 12'hF00;
`else
  localparam logic [11:0] CHAMP = 12'h000;
`endif
  localparam logic [11:0] BG = 12'h123;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0;

  // shared pixel / frame inputs
  logic        pix_en = 1'b0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic        active = 1'b0;
  logic        screen_end = 1'b0;
  logic [11:0] bg_color = BG;

  // default instance (DOT_SIZE=1)
  logic        wr_en = 1'b0, wr_is_y = 1'b0;
  logic [31:0] wr_id = '0, wr_data = '0;
  logic        wr_ack, hit_any;
  logic [11:0] rgb_out;
  logic [4:0]  hit_id;

  // second instance (DOT_SIZE=4)
  logic        wr_en4 = 1'b0, wr_is_y4 = 1'b0;
  logic [31:0] wr_id4 = '0, wr_data4 = '0;
  logic        wr_ack4, hit_any4;
  logic [11:0] rgb4;
  logic [4:0]  hit_id4;

  int n_tests = 0;
  int n_fail  = 0;

  dot_overlay_engine u_dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .active(active),
    .screen_end(screen_end), .wr_en(wr_en), .wr_is_y(wr_is_y), .wr_id(wr_id),
    .wr_data(wr_data), .wr_ack(wr_ack), .bg_color(bg_color), .rgb_out(rgb_out),
    .hit_any(hit_any), .hit_id(hit_id)
  );

  dot_overlay_engine #(.DOT_SIZE(4)) u_dut4 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .active(active),
    .screen_end(screen_end), .wr_en(wr_en4), .wr_is_y(wr_is_y4), .wr_id(wr_id4),
    .wr_data(wr_data4), .wr_ack(wr_ack4), .bg_color(bg_color), .rgb_out(rgb4),
    .hit_any(hit_any4), .hit_id(hit_id4)
  );

  // ---------------- driver tasks ----------------
  // One pixel through the pipeline; outputs are valid on return.
  task automatic px(input logic [9:0] xi, input logic [8:0] yi, input logic act);
    @(negedge clk);
    x = xi; y = yi; active = act; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
  endtask

  // Single write on one instance; returns 1 time unit after the write edge.
  task automatic do_write(input logic sel4, input logic is_y, input int id, input int data);
    @(negedge clk);
    if (sel4) begin wr_en4 = 1'b1; wr_is_y4 = is_y; wr_id4 = 32'(id); wr_data4 = 32'(data); end
    else      begin wr_en  = 1'b1; wr_is_y  = is_y; wr_id  = 32'(id); wr_data  = 32'(data); end
    @(posedge clk); #1;
    wr_en = 1'b0; wr_en4 = 1'b0;
  endtask

  // screen_end held high several clks, then low.
  task automatic frame_end();
    @(negedge clk); screen_end = 1'b1;
    repeat (3) @(negedge clk);
    screen_end = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    n_tests++; if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got %h want 000", rgb_out); end
    n_tests++; if (hit_any !== 1'b0) begin n_fail++; $display("FAIL reset_hit_any got %b want 0", hit_any); end
    n_tests++; if (hit_id !== 5'd0) begin n_fail++; $display("FAIL reset_hit_id got %0d want 0", hit_id); end
    n_tests++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ack got %b want 0", wr_ack); end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_home_frame();
    int cnt;
    frame_end();
    cnt = 0;
    for (int yi = 236; yi <= 244; yi++)
      for (int xi = 316; xi <= 324; xi++) begin
        px(10'(xi), 9'(yi), 1'b1);
        if (hit_any) cnt++;
      end
    n_tests++; if (cnt !== 1) begin n_fail++; $display("FAIL home_window_count got %0d want 1", cnt); end
    px(10'd320, 9'd240, 1'b1);
    n_tests++; if (hit_any !== 1'b1 || hit_id !== 5'd0) begin n_fail++; $display("FAIL home_hit got any=%b id=%0d want any=1 id=0", hit_any, hit_id); end
    n_tests++; if (rgb_out !== CHAMP) begin n_fail++; $display("FAIL home_rgb got %h want %h", rgb_out, CHAMP); end
    px(10'd315, 9'd55, 1'b1);
    n_tests++; if (rgb_out !== 12'h0D0) begin n_fail++; $display("FAIL goal_inside got %h want 0d0", rgb_out); end
    px(10'd329, 9'd69, 1'b1);
    n_tests++; if (rgb_out !== 12'h0D0) begin n_fail++; $display("FAIL goal_corner got %h want 0d0", rgb_out); end
    px(10'd330, 9'd55, 1'b1);
    n_tests++; if (rgb_out !== BG) begin n_fail++; $display("FAIL goal_right_edge got %h want %h", rgb_out, BG); end
    px(10'd315, 9'd49, 1'b1);
    n_tests++; if (rgb_out !== BG) begin n_fail++; $display("FAIL goal_top_edge got %h want %h", rgb_out, BG); end
    px(10'd5, 9'd5, 1'b0);
    n_tests++; if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL blank_rgb got %h want 000", rgb_out); end
  endtask

  task automatic test_write();
    do_write(1'b0, 1'b0, 3, 100);
    n_tests++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL wr_x_ack got %b want 1", wr_ack); end
    @(posedge clk); #1;
    n_tests++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL wr_x_ack_drop got %b want 0", wr_ack); end
    do_write(1'b0, 1'b1, 3, 50);
    n_tests++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL wr_y_ack got %b want 1", wr_ack); end
    px(10'd100, 9'd50, 1'b1);
    n_tests++; if (hit_any !== 1'b0 || rgb_out !== BG) begin n_fail++; $display("FAIL wr_before_commit got any=%b rgb=%h want any=0 rgb=%h", hit_any, rgb_out, BG); end
    frame_end();
    px(10'd100, 9'd50, 1'b1);
    n_tests++; if (hit_any !== 1'b1 || hit_id !== 5'd3 || rgb_out !== 12'h000) begin n_fail++; $display("FAIL wr_after_commit got any=%b id=%0d rgb=%h want any=1 id=3 rgb=000", hit_any, hit_id, rgb_out); end
  endtask

  task automatic test_discard();
    do_write(1'b0, 1'b0, 9, 5);
    n_tests++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL discard_ack got %b want 1", wr_ack); end
    do_write(1'b0, 1'b1, 8, 7);
    frame_end();
    px(10'd5, 9'd240, 1'b1);
    n_tests++; if (hit_any !== 1'b0) begin n_fail++; $display("FAIL discard_id9 got any=%b want 0", hit_any); end
    px(10'd320, 9'd240, 1'b1);
    n_tests++; if (hit_any !== 1'b1 || hit_id !== 5'd0) begin n_fail++; $display("FAIL discard_id8 got any=%b id=%0d want any=1 id=0", hit_any, hit_id); end
    px(10'd100, 9'd50, 1'b1);
    n_tests++; if (hit_id !== 5'd3) begin n_fail++; $display("FAIL discard_dot3 got id=%0d want 3", hit_id); end
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    @(negedge clk);
    wr_en = 1'b1; wr_is_y = 1'b0; wr_id = 32'd4; wr_data = 32'd400;
    @(negedge clk); if (wr_ack) acks++;
    wr_is_y = 1'b1; wr_data = 32'd300;
    @(negedge clk); if (wr_ack) acks++;
    wr_is_y = 1'b0; wr_id = 32'd6; wr_data = 32'd0;
    @(negedge clk); if (wr_ack) acks++;
    wr_is_y = 1'b1;
    @(negedge clk); if (wr_ack) acks++;
    wr_en = 1'b0;
    @(negedge clk);
    n_tests++; if (acks !== 4) begin n_fail++; $display("FAIL b2b_acks got %0d want 4", acks); end
    n_tests++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_end got %b want 0", wr_ack); end
    frame_end();
    px(10'd400, 9'd300, 1'b1);
    n_tests++; if (hit_any !== 1'b1 || hit_id !== 5'd4) begin n_fail++; $display("FAIL b2b_dot4 got any=%b id=%0d want any=1 id=4", hit_any, hit_id); end
    px(10'd0, 9'd0, 1'b1);
    n_tests++; if (hit_any !== 1'b1 || hit_id !== 5'd6) begin n_fail++; $display("FAIL b2b_dot6 got any=%b id=%0d want any=1 id=6", hit_any, hit_id); end
  endtask

  task automatic test_commit_collision();
    @(negedge clk);
    screen_end = 1'b1;
    wr_en = 1'b1; wr_is_y = 1'b0; wr_id = 32'd1; wr_data = 32'd200;
    @(negedge clk);
    wr_id = 32'd7; wr_data = 32'd50;   // screen_end still high: no commit
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    screen_end = 1'b0;
    @(negedge clk);
    px(10'd200, 9'd240, 1'b1);
    n_tests++; if (hit_any !== 1'b0) begin n_fail++; $display("FAIL collide_old_frame got any=%b want 0", hit_any); end
    px(10'd50, 9'd240, 1'b1);
    n_tests++; if (hit_any !== 1'b0) begin n_fail++; $display("FAIL held_high_no_commit got any=%b want 0", hit_any); end
    frame_end();
    px(10'd200, 9'd240, 1'b1);
    n_tests++; if (hit_any !== 1'b1 || hit_id !== 5'd1) begin n_fail++; $display("FAIL collide_next_frame got any=%b id=%0d want any=1 id=1", hit_any, hit_id); end
    px(10'd50, 9'd240, 1'b1);
    n_tests++; if (hit_id !== 5'd7) begin n_fail++; $display("FAIL held_write_next got id=%0d want 7", hit_id); end
  endtask

  task automatic test_async_reset();
    px(10'd100, 9'd50, 1'b1);
    do_write(1'b0, 1'b0, 0, 10);
    n_tests++; if (hit_any !== 1'b1 || wr_ack !== 1'b1 || rgb4 !== BG) begin n_fail++; $display("FAIL areset_pre got any=%b ack=%b rgb4=%h want 1 1 %h", hit_any, wr_ack, rgb4, BG); end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (hit_any !== 1'b0 || hit_id !== 5'd0 || wr_ack !== 1'b0 || rgb4 !== 12'h000) begin n_fail++; $display("FAIL areset_now got any=%b id=%0d ack=%b rgb4=%h want 0 0 0 000", hit_any, hit_id, wr_ack, rgb4); end
    @(negedge clk); reset = 1'b1;
    frame_end();
    px(10'd320, 9'd240, 1'b1);
    n_tests++; if (hit_any !== 1'b1 || hit_id !== 5'd0) begin n_fail++; $display("FAIL areset_home got any=%b id=%0d want any=1 id=0", hit_any, hit_id); end
    px(10'd10, 9'd240, 1'b1);
    n_tests++; if (hit_any !== 1'b0) begin n_fail++; $display("FAIL areset_lost_write got any=%b want 0", hit_any); end
    px(10'd400, 9'd300, 1'b1);
    n_tests++; if (hit_any !== 1'b0) begin n_fail++; $display("FAIL areset_dot4_home got any=%b want 0", hit_any); end
  endtask

  task automatic test_dot_size4();
    int bad;
    do_write(1'b1, 1'b0, 2, 638);
    n_tests++; if (wr_ack4 !== 1'b1) begin n_fail++; $display("FAIL size4_ack got %b want 1", wr_ack4); end
    do_write(1'b1, 1'b1, 2, 478);
    do_write(1'b1, 1'b0, 5, 638);
    do_write(1'b1, 1'b1, 5, 478);
    frame_end();
    bad = 0;
    for (int yi = 478; yi <= 479; yi++)
      for (int xi = 638; xi <= 639; xi++) begin
        px(10'(xi), 9'(yi), 1'b1);
        if (hit_any4 !== 1'b1 || hit_id4 !== 5'd2 || rgb4 !== 12'h000) bad++;
      end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL size4_corner got %0d bad pixels want 0", bad); end
    px(10'd637, 9'd479, 1'b1);
    n_tests++; if (hit_any4 !== 1'b0) begin n_fail++; $display("FAIL size4_left got any=%b want 0", hit_any4); end
    px(10'd0, 9'd0, 1'b1);
    n_tests++; if (hit_any4 !== 1'b0 || rgb4 !== BG) begin n_fail++; $display("FAIL size4_no_wrap got any=%b rgb=%h want 0 %h", hit_any4, rgb4, BG); end
    px(10'd323, 9'd243, 1'b1);
    n_tests++; if (hit_any4 !== 1'b1 || hit_id4 !== 5'd0 || rgb4 !== CHAMP) begin n_fail++; $display("FAIL size4_home got any=%b id=%0d rgb=%h want 1 0 %h", hit_any4, hit_id4, rgb4, CHAMP); end
    px(10'd324, 9'd240, 1'b1);
    n_tests++; if (hit_any4 !== 1'b0) begin n_fail++; $display("FAIL size4_home_edge got any=%b want 0", hit_any4); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_home_frame();
    test_write();
    test_discard();
    test_back_to_back();
    test_commit_collision();
    test_async_reset();
    test_dot_size4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
